// File: rtl/alu_issue_stage_if.sv
// Handshake and ALU-control bus between the decode/issue stage and its neighbours.
// slave is the issue stage; master is whoever drives instructions and sinks ops.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_is_branch;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    output in_ready, out_valid, out_alu_ctl, out_a, out_b, out_rd,
           out_reg_write, out_is_branch, out_funct3, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_alu_ctl, out_a, out_b, out_rd,
           out_reg_write, out_is_branch, out_funct3, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage: decodes ALU ops (incl. CTZ) and issues them
// through a main register backed by a one-entry skid register.
module alu_issue_stage (
  input  logic             clk,
  input  logic             rst,
  alu_issue_stage_if.slave bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CTL_W = 4;

  localparam logic [CTL_W-1:0] CTL_ADD  = 4'b0000;
  localparam logic [CTL_W-1:0] CTL_SUB  = 4'b0001;
  localparam logic [CTL_W-1:0] CTL_AND  = 4'b0010;
  localparam logic [CTL_W-1:0] CTL_OR   = 4'b0011;
  localparam logic [CTL_W-1:0] CTL_XOR  = 4'b0100;
  localparam logic [CTL_W-1:0] CTL_SLL  = 4'b0101;
  localparam logic [CTL_W-1:0] CTL_SRL  = 4'b0110;
  localparam logic [CTL_W-1:0] CTL_SRA  = 4'b0111;
  localparam logic [CTL_W-1:0] CTL_SLTU = 4'b1000;
  localparam logic [CTL_W-1:0] CTL_SLT  = 4'b1001;
  localparam logic [CTL_W-1:0] CTL_BCMP = 4'b1010;
  localparam logic [CTL_W-1:0] CTL_CTZ  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0]  F7_BASE = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;
  localparam logic [11:0] CTZ_HI  = 12'b0110000_00001;

  typedef struct packed {
    logic [CTL_W-1:0] ctl;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [4:0]       rd;
    logic             reg_write;
    logic             is_branch;
    logic [2:0]       funct3;
    logic             illegal;
  } issue_op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Shared funct3 -> ALUCtl map for OP / OP-IMM base encodings.
  function automatic logic [CTL_W-1:0] base_ctl(input logic [2:0] f3);
    case (f3)
      3'b000:  return CTL_ADD;
      3'b001:  return CTL_SLL;
      3'b010:  return CTL_SLT;
      3'b011:  return CTL_SLTU;
      3'b100:  return CTL_XOR;
      3'b101:  return CTL_SRL;
      3'b110:  return CTL_OR;
      default: return CTL_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u  = {bus.in_instr[31:12], 12'b0};
  assign shamt  = XLEN'(bus.in_instr[24:20]);

  issue_op_t dec_c;
  logic      legal_c;

  always_comb begin
    dec_c        = '0;
    legal_c      = 1'b1;
    dec_c.rd     = bus.in_instr[11:7];
    dec_c.funct3 = funct3;
    case (opcode)
      OPC_OP: begin
        dec_c.a = bus.in_rs1_data;
        dec_c.b = bus.in_rs2_data;
        if (funct7 == F7_BASE) begin
          dec_c.ctl = base_ctl(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_c.ctl = CTL_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_c.ctl = CTL_SRA;
        end else begin
          legal_c = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_c.a   = bus.in_rs1_data;
        dec_c.b   = imm_i;
        dec_c.ctl = base_ctl(funct3);
        // CTZ lives in the SLLI encoding space with a non-zero funct7.
        if (funct3 == 3'b001) begin
          if (bus.in_instr[31:20] == CTZ_HI) begin
            dec_c.ctl = CTL_CTZ;
            dec_c.b   = '0;
          end else begin
            dec_c.b = shamt;
            legal_c = (funct7 == F7_BASE);
          end
        end else if (funct3 == 3'b101) begin
          dec_c.b = shamt;
          if (funct7 == F7_ALT) begin
            dec_c.ctl = CTL_SRA;
          end else begin
            legal_c = (funct7 == F7_BASE);
          end
        end
      end
      OPC_LUI: begin
        dec_c.ctl = CTL_ADD;
        dec_c.b   = imm_u;
      end
      OPC_AUIPC: begin
        dec_c.ctl = CTL_ADD;
        dec_c.a   = bus.in_pc;
        dec_c.b   = imm_u;
      end
      OPC_BRANCH: begin
        dec_c.is_branch = 1'b1;
        dec_c.a         = bus.in_rs1_data;
        dec_c.b         = bus.in_rs2_data;
        case (funct3[2:1])
          2'b00:   dec_c.ctl = CTL_BCMP;
          2'b10:   dec_c.ctl = CTL_SLT;
          2'b11:   dec_c.ctl = CTL_SLTU;
          default: legal_c   = 1'b0;
        endcase
      end
      default: legal_c = 1'b0;
    endcase
    if (!legal_c) begin
      dec_c.ctl       = CTL_ADD;
      dec_c.a         = '0;
      dec_c.b         = '0;
      dec_c.is_branch = 1'b0;
      dec_c.reg_write = 1'b0;
      dec_c.illegal   = 1'b1;
    end else begin
      dec_c.reg_write = !dec_c.is_branch;
    end
  end

  buf_state_e state_q, state_d;
  issue_op_t  main_q, main_d;
  issue_op_t  skid_q, skid_d;
  logic       in_ready_c;
  logic       accept_c;
  logic       consume_c;

  assign in_ready_c = (state_q != ST_FULL) && !rst;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign consume_c  = (state_q != ST_EMPTY) && bus.out_ready;

  // Skid buffer occupancy; flush wins over any acceptance this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_d  = dec_c;
            state_d = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept_c && consume_c) begin
            main_d = dec_c;
          end else if (accept_c) begin
            skid_d  = dec_c;
            state_d = ST_FULL;
          end else if (consume_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume_c) begin
            main_d  = skid_q;
            state_d = ST_MAIN;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = (state_q != ST_EMPTY);
  assign bus.out_alu_ctl   = main_q.ctl;
  assign bus.out_a         = main_q.a;
  assign bus.out_b         = main_q.b;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_reg_write = main_q.reg_write;
  assign bus.out_is_branch = main_q.is_branch;
  assign bus.out_funct3    = main_q.funct3;
  assign bus.out_illegal   = main_q.illegal;
endmodule
